// File: rtl/phase_sequencer.sv
// Run/stop/single-step controller: steps the per-instruction phase index, issues
// one-hot phase enables, strobes the register-file clear and counts retired instructions.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  mem_wait,
  output logic [2:0]            phase,
  output logic [NUM_PHASES-1:0] p_en,
  output logic                  register_reset,
  output logic                  running,
  output logic [CNT_W-1:0]      inst_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

  state_t                  state, state_nx;
  logic [2:0]              phase_nx;
  logic [NUM_PHASES-1:0]   p_en_nx;
  logic [CNT_W-1:0]        count_nx;
  logic                    running_nx;
  logic                    rr_nx;
  logic                    stop_pend, stop_pend_nx;
  logic                    exec_q, step_q;
  logic                    exec_r, step_r;

  assign exec_r    = exec & ~exec_q;
  assign step_r    = step & ~step_q;
  assign dbg_state = state;

  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    count_nx     = inst_count;
    stop_pend_nx = stop_pend;
    case (state)
      INIT: begin
        state_nx = IDLE;
        phase_nx = 3'd0;
      end
      IDLE: begin
        phase_nx     = 3'd0;
        stop_pend_nx = 1'b0;
        if (exec_r)      state_nx = RUN;
        else if (step_r) state_nx = STEP;
      end
      RUN, STEP: begin
        // A stop request only arms; the current instruction always completes.
        if (state == RUN && exec_r) stop_pend_nx = 1'b1;
        if (!mem_wait) begin
          if (phase != LAST_PHASE) begin
            phase_nx = phase + 3'd1;
          end else begin
            count_nx = inst_count + 1'b1;
            phase_nx = 3'd0;
            if (halt_req) begin
              state_nx     = HALTED;
              stop_pend_nx = 1'b0;
            end else if (state == STEP || stop_pend_nx) begin
              state_nx     = IDLE;
              stop_pend_nx = 1'b0;
            end
          end
        end
      end
      HALTED: phase_nx = 3'd0;
      default: begin
        state_nx = INIT;
        phase_nx = 3'd0;
      end
    endcase

    // Outputs are registered from the next state so they track it cycle-exactly.
    running_nx = (state_nx == RUN) || (state_nx == STEP);
    p_en_nx    = running_nx ? (NUM_PHASES'(1) << phase_nx) : '0;
    rr_nx      = (state_nx == INIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT;
      phase          <= 3'd0;
      p_en           <= '0;
      running        <= 1'b0;
      inst_count     <= '0;
      register_reset <= 1'b1;
      stop_pend      <= 1'b0;
      exec_q         <= 1'b1;
      step_q         <= 1'b1;
    end else begin
      state          <= state_nx;
      phase          <= phase_nx;
      p_en           <= p_en_nx;
      running        <= running_nx;
      inst_count     <= count_nx;
      register_reset <= rr_nx;
      stop_pend      <= stop_pend_nx;
      exec_q         <= exec;
      step_q         <= step;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed, table-driven bench for phase_sequencer; a second instance with a
// 4-bit counter shares all stimulus so counter wrap-around can be observed.
module tb_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset, exec, step, halt_req, mem_wait;
  logic [2:0]  phase, phase4;
  logic [4:0]  p_en, p_en4;
  logic        register_reset, running, register_reset4, running4;
  logic [15:0] inst_count;
  logic [3:0]  inst_count4;
  logic [2:0]  dbg_state, dbg_state4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step),
    .halt_req(halt_req), .mem_wait(mem_wait), .phase(phase), .p_en(p_en),
    .register_reset(register_reset), .running(running),
    .inst_count(inst_count), .dbg_state(dbg_state)
  );

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .exec(exec), .step(step),
    .halt_req(halt_req), .mem_wait(mem_wait), .phase(phase4), .p_en(p_en4),
    .register_reset(register_reset4), .running(running4),
    .inst_count(inst_count4), .dbg_state(dbg_state4)
  );

  typedef struct {
    logic       rst, ex, st, hr, mw;
    logic [2:0] ph;
    logic [4:0] pen;
    logic       run, rr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  logic [25:0] exp_q[$];

  task automatic add(input logic rst, ex, st, hr, mw, input logic [2:0] ph,
                     input logic [4:0] pen, input logic run, rr, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.ex = ex; v.st = st; v.hr = hr; v.mw = mw;
    v.ph = ph; v.pen = pen; v.run = run; v.rr = rr; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, ex, st, hr, mw);
    reset = rst; exec = ex; step = st; halt_req = hr; mem_wait = mw;
  endtask

  task automatic expect_out(input logic [2:0] ph, input logic [4:0] pen,
                            input logic run, rr, input logic [15:0] cnt);
    exp_q.push_back({ph, pen, run, rr, cnt});
  endtask

  // Compares both instances against the oldest queued expectation.
  task automatic check(input string name);
    logic [25:0] exp, act;
    logic [3:0]  exp_cnt4;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no expected value queued", name);
      return;
    end
    exp = exp_q.pop_front();
    exp_cnt4 = exp[3:0];
    act = {phase, p_en, running, register_reset, inst_count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ph=%0d p_en=%b run=%b rr=%b cnt=%0d, expected ph=%0d p_en=%b run=%b rr=%b cnt=%0d",
               name, act[25:23], act[22:18], act[17], act[16], act[15:0],
               exp[25:23], exp[22:18], exp[17], exp[16], exp[15:0]);
    end
    checks++;
    if (inst_count4 !== exp_cnt4) begin
      errors++;
      $display("FAIL %s cnt4: got %0d expected %0d", name, inst_count4, exp_cnt4);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    //  rst ex st hr mw   ph  p_en      run rr cnt
    // reset, then one cycle of register clear, then idle
    add(1, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
    // exec pulse, two full instructions
    add(0, 1, 0, 0, 0, 0, 5'b00001, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 5'b00100, 1, 0, 0);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2, 5'b00100, 1, 0, 1);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 1);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 2);
    // mem_wait stall at phase 2
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 2);
    add(0, 0, 0, 0, 0, 2, 5'b00100, 1, 0, 2);
    add(0, 0, 0, 0, 1, 2, 5'b00100, 1, 0, 2);
    add(0, 0, 0, 0, 1, 2, 5'b00100, 1, 0, 2);
    add(0, 0, 0, 0, 1, 2, 5'b00100, 1, 0, 2);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 2);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 3);
    // stop request at phase 1: instruction completes, then idle
    add(0, 1, 0, 0, 0, 2, 5'b00100, 1, 0, 3);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 3);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 4);
    // single step
    add(0, 0, 1, 0, 0, 0, 5'b00001, 1, 0, 4);
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 4);
    add(0, 0, 0, 0, 0, 2, 5'b00100, 1, 0, 4);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 4);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 5);
    // second step; exec during STEP is ignored
    add(0, 0, 1, 0, 0, 0, 5'b00001, 1, 0, 5);
    add(0, 1, 0, 0, 0, 1, 5'b00010, 1, 0, 5);
    add(0, 0, 0, 0, 0, 2, 5'b00100, 1, 0, 5);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 5);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 5);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 6);
    // exec and step together start RUN (keeps going past the boundary)
    add(0, 1, 1, 0, 0, 0, 5'b00001, 1, 0, 6);
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 6);
    add(0, 0, 0, 0, 0, 2, 5'b00100, 1, 0, 6);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 6);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 6);
    add(0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 7);
    // halt_req outside the last phase is ignored; stall defers the boundary
    add(0, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 7);
    add(0, 0, 0, 1, 0, 2, 5'b00100, 1, 0, 7);
    add(0, 0, 0, 0, 0, 3, 5'b01000, 1, 0, 7);
    add(0, 0, 0, 0, 0, 4, 5'b10000, 1, 0, 7);
    add(0, 0, 0, 0, 1, 4, 5'b10000, 1, 0, 7);
    add(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 8);
    // HALTED ignores exec and step
    add(0, 1, 0, 0, 0, 0, 5'b00000, 0, 0, 8);
    add(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 8);
    // reset recovers; exec held through reset does not start
    add(1, 1, 0, 0, 0, 0, 5'b00000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].ex, vq[i].st, vq[i].hr, vq[i].mw);
      expect_out(vq[i].ph, vq[i].pen, vq[i].run, vq[i].rr, vq[i].cnt);
      tick();
      check($sformatf("vec%0d", i));
    end

    // 16 instructions: 16-bit counter reads 16, 4-bit counter wraps to 0
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 80; k++) tick();
    expect_out(3'd0, 5'b00001, 1'b1, 1'b0, 16'd16);
    check("wrap16");

    // reset mid-instruction: reset values, no partial count
    tick();
    tick();
    expect_out(3'd2, 5'b00100, 1'b1, 1'b0, 16'd16);
    check("mid_instr");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out(3'd0, 5'b00000, 1'b0, 1'b1, 16'd0);
    check("mid_reset");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out(3'd0, 5'b00000, 1'b0, 1'b0, 16'd0);
    check("post_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
